// File: rtl/spi_adc_reader.sv
// SPI mode-0 master that periodically reads a 12-bit serial ADC and presents the result.
// Optional ADC_AVG4_EN: publish the truncated mean of every four frames instead of each frame.
module spi_adc_reader #(
  parameter int unsigned CLK_DIV       = 25,
  parameter int unsigned LEAD_BITS     = 3,
  parameter int unsigned SAMPLE_PERIOD = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        adc_miso,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic [11:0] adc_value,
  output logic        adc_valid,
  output logic        busy
);

  localparam int unsigned FrameBits = LEAD_BITS + 12;
  localparam int unsigned DivW      = (CLK_DIV > 1) ? $clog2(CLK_DIV + 1) : 1;
  localparam int unsigned PerW      = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned BitW      = $clog2(FrameBits + 1);

  localparam logic [DivW-1:0] DivTerm  = DivW'(CLK_DIV - 1);
  localparam logic [PerW-1:0] PerTerm  = PerW'(SAMPLE_PERIOD - 1);
  localparam logic [BitW-1:0] BitTerm  = BitW'(FrameBits);

  typedef enum logic [1:0] {StIdle, StSetup, StShift} state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [DivW-1:0]   guard_q, guard_d;
  logic [PerW-1:0]   per_q, per_d;
  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [11:0]       shift_q, shift_d;
  logic [11:0]       value_q, value_d;
  logic              pending_q, pending_d;
  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              start_req;
  logic              guard_ok;
`ifdef ADC_AVG4_EN
  logic [13:0]       acc_q, acc_d;
  logic [1:0]        fcnt_q, fcnt_d;
  logic [13:0]       acc_sum;
`endif

  // The guard is treated as expired on the edge where it counts down to zero.
  assign guard_ok  = (guard_q <= DivW'(1));
  assign start_req = pending_q || (per_q == '0);

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    guard_d   = guard_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    value_d   = value_q;
    pending_d = pending_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    valid_d   = 1'b0;
    per_d     = (per_q == PerTerm) ? '0 : per_q + PerW'(1);
`ifdef ADC_AVG4_EN
    acc_d     = acc_q;
    fcnt_d    = fcnt_q;
    acc_sum   = acc_q + 14'(shift_q);
`endif

    if (per_q == '0) pending_d = 1'b1;
    if (guard_q != '0) guard_d = guard_q - DivW'(1);

    unique case (state_q)
      StIdle: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b0;
        if (start_req && guard_ok) begin
          state_d   = StSetup;
          cs_n_d    = 1'b0;
          pending_d = 1'b0;
          div_d     = '0;
          bit_cnt_d = '0;
        end
      end
      StSetup: begin
        if (div_q == DivTerm) begin
          div_d   = '0;
          state_d = StShift;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StShift: begin
        if (div_q == DivTerm) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            shift_d   = {shift_q[10:0], adc_miso};
            bit_cnt_d = bit_cnt_q + BitW'(1);
          end else if (bit_cnt_q == BitTerm) begin
            state_d = StIdle;
            cs_n_d  = 1'b1;
            guard_d = DivW'(CLK_DIV);
`ifdef ADC_AVG4_EN
            if (fcnt_q == 2'd3) begin
              value_d = 12'(acc_sum >> 2);
              valid_d = 1'b1;
              acc_d   = '0;
              fcnt_d  = '0;
            end else begin
              acc_d  = acc_sum;
              fcnt_d = fcnt_q + 2'd1;
            end
`else
            value_d = shift_q;
            valid_d = 1'b1;
`endif
          end
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = ~cs_n_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      div_q     <= '0;
      guard_q   <= '0;
      per_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      value_q   <= '0;
      pending_q <= 1'b0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef ADC_AVG4_EN
      acc_q     <= '0;
      fcnt_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      guard_q   <= guard_d;
      per_q     <= per_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      value_q   <= value_d;
      pending_q <= pending_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
`ifdef ADC_AVG4_EN
      acc_q     <= acc_d;
      fcnt_q    <= fcnt_d;
`endif
    end
  end

  assign adc_cs_n  = cs_n_q;
  assign adc_sclk  = sclk_q;
  assign adc_value = value_q;
  assign adc_valid = valid_q;
  assign busy      = busy_q;

endmodule
